// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the CPU-device bridge
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Word offsets inside the internal register window
  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;

  // cpu_addr[31:4] of device slot 0
  localparam logic [27:0] DEFAULT_BASE = 28'h00007F0;

endpackage

// File: rtl/io_bridge_if.sv
// rtl/io_bridge_if.sv - CPU-side and device-side bus bundles for the bridge
interface io_cpu_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        irq;

  modport master (output req, we, addr, be, wdata, input rdata, ready, err, irq);
  modport slave  (input req, we, addr, be, wdata, output rdata, ready, err, irq);
endinterface

interface io_dev_if #(
  parameter int NUM_DEV = 4
);
  logic [NUM_DEV-1:0]    sel;
  logic                  we;
  logic [1:0]            addr;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [32*NUM_DEV-1:0] rdata;
  logic [NUM_DEV-1:0]    ack;
  logic [NUM_DEV-1:0]    irq;

  modport master (output sel, we, addr, be, wdata, input rdata, ack, irq);
  modport slave  (input sel, we, addr, be, wdata, output rdata, ack, irq);
endinterface

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - combinational slot decode of cpu_addr[31:4]
module io_addr_decode
  import io_bridge_pkg::*;
#(
  parameter int          NUM_DEV = 4,
  parameter logic [27:0] BASE    = DEFAULT_BASE
) (
  input  logic [27:0]        win,
  output logic [NUM_DEV-1:0] hit,
  output logic               internal,
  output logic               unmapped
);

  logic [27:0] diff;

  // Addresses below BASE wrap to a large offset and fall out as unmapped
  assign diff = win - BASE;

  // One-hot slot hit, internal window right after the last slot
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      hit[i] = (diff == 28'(i));
    end
    internal = (diff == 28'(NUM_DEV));
    unmapped = ~(|hit) & ~internal;
  end

endmodule

// File: rtl/io_bridge_n.sv
// rtl/io_bridge_n.sv - handshaked CPU-to-device address bridge with irq/error registers
module io_bridge_n
  import io_bridge_pkg::*;
#(
  parameter int          NUM_DEV = 4,
  parameter logic [27:0] BASE    = DEFAULT_BASE,
  parameter int          TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  io_cpu_if.slave  cpu,
  io_dev_if.master dev
);

  state_t             state;
  logic [7:0]         cnt;
  logic [NUM_DEV-1:0] hit;
  logic               internal;
  logic               unmapped;
  logic               ack_hit;
  logic [NUM_DEV-1:0] mask;
  logic [NUM_DEV-1:0] mask_next;
  logic [NUM_DEV-1:0] pend;
  logic [29:0]        err_addr;
  logic [31:0]        be_bits;
  logic [31:0]        sel_rdata;
  logic [31:0]        int_rdata;

  io_addr_decode #(
    .NUM_DEV (NUM_DEV),
    .BASE    (BASE)
  ) u_decode (
    .win      (cpu.addr[29:2]),
    .hit      (hit),
    .internal (internal),
    .unmapped (unmapped)
  );

  // Only the acknowledge of the strobed slot counts
  assign ack_hit = |(dev.ack & dev.sel);

  assign be_bits   = {{8{cpu.be[3]}}, {8{cpu.be[2]}}, {8{cpu.be[1]}}, {8{cpu.be[0]}}};
  assign mask_next = (mask & ~be_bits[NUM_DEV-1:0]) | (cpu.wdata[NUM_DEV-1:0] & be_bits[NUM_DEV-1:0]);

  assign cpu.irq = |(pend & mask);

  // Read data of the strobed slot; dev.sel is one-hot or all zero
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev.sel[i]) sel_rdata = sel_rdata | dev.rdata[32*i +: 32];
    end
  end

  // Internal register read mux by word offset
  always_comb begin
    int_rdata = '0;
    case (cpu.addr[1:0])
      IRQ_MASK: int_rdata = 32'(mask);
      IRQ_PEND: int_rdata = 32'(pend);
      ERR_ADDR: int_rdata = {err_addr, 2'b00};
      default:  int_rdata = '0;
    endcase
  end

  // Device interrupt levels registered into the pending register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= dev.irq;
    end
  end

  // Access sequencer: decode in IDLE, wait for ack or timeout in ACCESS, one-cycle response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dev.sel   <= '0;
      dev.we    <= 1'b0;
      dev.addr  <= '0;
      dev.be    <= '0;
      dev.wdata <= '0;
      cpu.ready <= 1'b0;
      cpu.err   <= 1'b0;
      cpu.rdata <= '0;
      mask      <= '0;
      err_addr  <= '0;
    end else begin
      cpu.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.req) begin
            if (internal) begin
              if (cpu.we && (cpu.addr[1:0] == IRQ_MASK)) mask <= mask_next;
              cpu.rdata <= cpu.we ? 32'd0 : int_rdata;
              cpu.err   <= 1'b0;
              cpu.ready <= 1'b1;
              state     <= RESP;
            end else if (unmapped) begin
              cpu.rdata <= '0;
              cpu.err   <= 1'b1;
              cpu.ready <= 1'b1;
              err_addr  <= cpu.addr;
              state     <= RESP;
            end else begin
              dev.sel   <= hit;
              dev.we    <= cpu.we;
              dev.addr  <= cpu.addr[1:0];
              dev.be    <= cpu.be;
              dev.wdata <= cpu.wdata;
              cnt       <= '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            cpu.rdata <= sel_rdata;
            cpu.err   <= 1'b0;
            cpu.ready <= 1'b1;
            dev.sel   <= '0;
            state     <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            cpu.rdata <= '0;
            cpu.err   <= 1'b1;
            cpu.ready <= 1'b1;
            dev.sel   <= '0;
            err_addr  <= cpu.addr;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bridge_n.sv
// tb/tb_io_bridge_n.sv - self-checking bench for io_bridge_n
module tb_io_bridge_n;
  import io_bridge_pkg::*;

  localparam int          ND = 4;
  localparam int          TO = 15;
  localparam logic [27:0] B  = 28'h00007F0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  io_cpu_if cpu_bus ();
  io_dev_if #(.NUM_DEV(ND)) dev_bus ();

  io_bridge_n #(
    .NUM_DEV (ND),
    .BASE    (B),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_bus),
    .dev   (dev_bus)
  );

  int tests = 0;
  int fails = 0;

  // Device model: ack from the strobed slot once it has been strobed ack_dly extra cycles
  bit            ack_en  = 1'b0;
  int            ack_dly = 0;
  logic [ND-1:0] stray   = '0;
  int            sel_cnt = 0;

  always @(posedge clk) sel_cnt <= (|dev_bus.sel) ? sel_cnt + 1 : 0;

  assign dev_bus.ack   = stray | ((ack_en && (sel_cnt >= ack_dly)) ? dev_bus.sel : '0);
  assign dev_bus.rdata = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  typedef struct {
    logic          we;
    logic [29:0]   addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    int            dly;
    logic [ND-1:0] stray;
    logic [31:0]   rdata;
    logic          err;
    int            lat;
    int            selc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          lat;
    int          selc;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] wa(input logic [27:0] win, input logic [1:0] off);
    return {win, off};
  endfunction

  // Drive one access from IDLE, follow it to cpu_ready, compare against the scoreboard
  task automatic run(input vec_t v, input string tag);
    exp_t        e;
    exp_t        got;
    int          lat  = 0;
    int          selc = 0;
    bit          seen = 1'b0;
    bit          done = 1'b0;
    logic [27:0] slot;
    e = '{v.rdata, v.err, ~v.we, v.lat, v.selc};
    sbq.push_back(e);
    ack_en        = (v.dly >= 0);
    ack_dly       = (v.dly < 0) ? 0 : v.dly;
    stray         = v.stray;
    cpu_bus.we    = v.we;
    cpu_bus.addr  = v.addr;
    cpu_bus.be    = v.be;
    cpu_bus.wdata = v.wdata;
    cpu_bus.req   = 1'b1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (|dev_bus.sel) begin
        selc++;
        if (!seen) begin
          seen = 1'b1;
          slot = v.addr[29:2] - B;
          chk({tag, " sel"},   32'(dev_bus.sel),  32'd1 << slot);
          chk({tag, " we"},    32'(dev_bus.we),   32'(v.we));
          chk({tag, " daddr"}, 32'(dev_bus.addr), 32'(v.addr[1:0]));
          chk({tag, " be"},    32'(dev_bus.be),   32'(v.be));
          chk({tag, " wdata"}, dev_bus.wdata,     v.wdata);
        end
      end
      if (cpu_bus.ready === 1'b1) done = 1'b1;
    end
    cpu_bus.req = 1'b0;
    stray       = '0;
    ack_en      = 1'b0;
    got         = sbq.pop_front();
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s no_ready: got none expected ready within 100 cycles", tag);
    end else begin
      chk({tag, " err"},  32'(cpu_bus.err), 32'(got.err));
      if (got.chk_rd) chk({tag, " rdata"}, cpu_bus.rdata, got.rdata);
      chk({tag, " lat"},  32'(lat),  32'(got.lat));
      chk({tag, " selc"}, 32'(selc), 32'(got.selc));
      chk({tag, " sel_off"}, 32'(dev_bus.sel), 32'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, 32'(cpu_bus.ready), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   rdy_seen;

    //         we    addr                  be       wdata          dly stray    rdata          err lat selc
    vt[0]  = '{1'b0, wa(B + 28'd1, 2'd0), 4'hF,    32'h0,         0,  4'h0,    32'hCAFE0001,  1'b0, 2, 1};
    vt[1]  = '{1'b1, wa(B + 28'd2, 2'd3), 4'b0011, 32'h12345678,  3,  4'h0,    32'h0,         1'b0, 5, 4};
    vt[2]  = '{1'b0, wa(B + 28'd3, 2'd1), 4'hF,    32'h0,         1,  4'h0,    32'hCAFE0003,  1'b0, 3, 2};
    vt[3]  = '{1'b0, wa(B,          2'd0), 4'hF,   32'h0,         -1, 4'h0,    32'h0,         1'b1, 16, 15};
    vt[4]  = '{1'b0, wa(B + 28'd4, 2'd2), 4'hF,    32'h0,         -1, 4'h0,    32'h00007F00,  1'b0, 1, 0};
    vt[5]  = '{1'b0, wa(28'h800,   2'd1), 4'hF,    32'h0,         -1, 4'h0,    32'h0,         1'b1, 1, 0};
    vt[6]  = '{1'b0, wa(B + 28'd4, 2'd2), 4'hF,    32'h0,         -1, 4'h0,    32'h00008004,  1'b0, 1, 0};
    vt[7]  = '{1'b1, wa(B + 28'd4, 2'd0), 4'b0001, 32'h00000004,  -1, 4'h0,    32'h0,         1'b0, 1, 0};
    vt[8]  = '{1'b1, wa(B + 28'd4, 2'd0), 4'b0000, 32'h0000000F,  -1, 4'h0,    32'h0,         1'b0, 1, 0};
    vt[9]  = '{1'b0, wa(B + 28'd4, 2'd0), 4'hF,    32'h0,         -1, 4'h0,    32'h00000004,  1'b0, 1, 0};
    vt[10] = '{1'b1, wa(B + 28'd4, 2'd1), 4'hF,    32'h0000000F,  -1, 4'h0,    32'h0,         1'b0, 1, 0};
    vt[11] = '{1'b0, wa(B + 28'd4, 2'd3), 4'hF,    32'h0,         -1, 4'h0,    32'h0,         1'b0, 1, 0};
    vt[12] = '{1'b0, wa(28'h7EF,   2'd0), 4'hF,    32'h0,         -1, 4'h0,    32'h0,         1'b1, 1, 0};
    vt[13] = '{1'b0, wa(B + 28'd3, 2'd2), 4'hF,    32'h0,         14, 4'h0,    32'hCAFE0003,  1'b0, 16, 15};
    vt[14] = '{1'b0, wa(B,          2'd1), 4'hF,   32'h0,         -1, 4'b1110, 32'h0,         1'b1, 16, 15};

    rst_n         = 1'b0;
    cpu_bus.req   = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.addr  = '0;
    cpu_bus.be    = '0;
    cpu_bus.wdata = '0;
    dev_bus.irq   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst ready", 32'(cpu_bus.ready), 32'd0);
    chk("rst err",   32'(cpu_bus.err),   32'd0);
    chk("rst rdata", cpu_bus.rdata,      32'd0);
    chk("rst irq",   32'(cpu_bus.irq),   32'd0);
    chk("rst sel",   32'(dev_bus.sel),   32'd0);
    chk("rst dwe",   32'(dev_bus.we),    32'd0);
    chk("rst daddr", 32'(dev_bus.addr),  32'd0);
    chk("rst dbe",   32'(dev_bus.be),    32'd0);
    chk("rst dwdat", dev_bus.wdata,      32'd0);

    for (int i = 0; i < 15; i++) begin
      run(vt[i], $sformatf("vec%0d", i));
    end

    // Interrupt path: mask is 4'b0100 after the table
    chk("irq idle", 32'(cpu_bus.irq), 32'd0);
    dev_bus.irq = 4'b0100;
    #1;
    chk("irq same_cycle", 32'(cpu_bus.irq), 32'd0);
    @(posedge clk);
    #1;
    chk("irq rise", 32'(cpu_bus.irq), 32'd1);
    dev_bus.irq = 4'b0110;
    @(posedge clk);
    #1;
    chk("irq hold", 32'(cpu_bus.irq), 32'd1);
    v = '{1'b0, wa(B + 28'd4, 2'd1), 4'hF, 32'h0, -1, 4'h0, 32'h00000006, 1'b0, 1, 0};
    run(v, "pend");
    dev_bus.irq = 4'b0010;
    @(posedge clk);
    #1;
    chk("irq masked", 32'(cpu_bus.irq), 32'd0);

    // Reset while a slot-0 access is waiting for an ack that never comes
    ack_en        = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.addr  = wa(B, 2'd0);
    cpu_bus.be    = 4'hF;
    cpu_bus.wdata = '0;
    cpu_bus.req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid sel", 32'(dev_bus.sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort sel",   32'(dev_bus.sel),   32'd0);
    chk("abort ready", 32'(cpu_bus.ready), 32'd0);
    chk("abort irq",   32'(cpu_bus.irq),   32'd0);
    chk("abort state", 32'(dut.state),     32'(IDLE));
    cpu_bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (cpu_bus.ready === 1'b1) rdy_seen++;
    end
    chk("abort no_resp", 32'(rdy_seen), 32'd0);
    v = '{1'b0, wa(B + 28'd4, 2'd0), 4'hF, 32'h0, -1, 4'h0, 32'h0, 1'b0, 1, 0};
    run(v, "post mask");
    v = '{1'b0, wa(B + 28'd1, 2'd0), 4'hF, 32'h0, 0, 4'h0, 32'hCAFE0001, 1'b0, 2, 1};
    run(v, "post rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_bridge_n.md
# io_bridge_n

Parametrised, handshaked successor to the CPU–device address bridge. It decodes CPU data accesses into one of `NUM_DEV` 16-byte device windows and drives the selected device with a registered strobe. It waits for a per-device acknowledge, bounded by a timeout, then returns registered read data with a ready/error response. It also holds a small internal register window for interrupt mask, interrupt pending and last-error address. It sits between the CPU data port and the peripheral set: counter, switches, digit display, UART and future devices.

## Interface
- `NUM_DEV`, 4: number of device slots, 1..15.
- `BASE`, 28'h00007F0: `cpu_addr[31:4]` of slot 0. Slot i is at `BASE+i`. The internal window is at `BASE+NUM_DEV`.
- `TIMEOUT`, 15: maximum cycles to wait for `dev_ack`, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request. Held with its address and data until `cpu_ready`.
- `cpu_we` in 1: write enable.
- `cpu_addr` in 30: word address [31:2].
- `cpu_be` in 4: byte enables.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: registered read data. Valid while `cpu_ready`.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_ready`. Set for unmapped address or timeout.
- `cpu_irq` out 1: `|(pending & mask)`.
- `dev_sel` out NUM_DEV: one-hot device strobe.
- `dev_we` out 1: registered copy of `cpu_we`.
- `dev_addr` out 2: registered copy of `cpu_addr[3:2]`.
- `dev_be` out 4: registered copy of `cpu_be`.
- `dev_wdata` out 32: registered copy of `cpu_wdata`.
- `dev_rdata` in 32*NUM_DEV: flattened read data. Slot i is bits [32i+31:32i].
- `dev_ack` in NUM_DEV: per-slot completion. May be combinational from `dev_sel`.
- `dev_irq` in NUM_DEV: level interrupt requests.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**, with `cpu_req` high, decodes `cpu_addr[31:4]`:
  - Device hit on slot i: register the `dev_*` fields, set `dev_sel[i]`, clear the timeout counter, go to ACCESS.
  - Internal hit: perform the register read or write, go to RESP with err=0.
  - Otherwise: go to RESP with err=1, rdata=0, and latch the error address.
- **ACCESS**:
  - `dev_ack[i]` high: capture `dev_rdata[i]`, drop `dev_sel`, go to RESP with err=0.
  - Counter == TIMEOUT-1 without ack: drop `dev_sel`, go to RESP with err=1, rdata=0, latch the error address.
  - Acks on non-selected slots are ignored.
- **RESP**: `cpu_ready`=1 for exactly one cycle, then IDLE. `cpu_req` is not resampled in RESP.
- Internal window, by word offset:
  - 0: irq mask, R/W, honours `cpu_be`.
  - 1: pending = registered `dev_irq`, read-only. Writes are ignored with err=0.
  - 2: last error word address, zero-extended {addr,2'b00}, read-only.
  - 3: reads 0.
- Reset values:
  - FSM = IDLE.
  - `dev_sel`=0, `cpu_ready`=0, `cpu_err`=0, `cpu_rdata`=0.
  - All `dev_*` registers = 0.
  - mask = 0, pending = 0, error address = 0, `cpu_irq`=0.
- Reset mid-access returns the FSM to IDLE immediately. No response is produced for the aborted access.

## Timing
- Accept at edge k. `dev_sel` is high from k to k+1.
- Combinational ack gives `cpu_ready` in cycle k+1..k+2. This is the minimum device latency of 2 cycles.
- An ack n cycles late gives `cpu_ready` n cycles later.
- Timeout: `dev_sel` stays high for exactly TIMEOUT cycles, then RESP.
- Internal and unmapped accesses: `cpu_ready` is asserted in cycle k..k+1, a latency of 1 cycle.
- `dev_irq` to `cpu_irq` is 1 cycle, registered through pending.
- At most one access is in flight. Back-to-back accesses have one IDLE cycle between them.

## Structure
- Shared package `io_bridge_pkg`: FSM state typedef, internal-register offsets (`IRQ_MASK`, `IRQ_PEND`, `ERR_ADDR`), default `BASE` constant.
- One sub-module, `io_addr_decode`: combinational slot decode producing a one-hot hit plus internal and unmapped flags. It is parametrised by `NUM_DEV` and `BASE`.

## Test plan
- Read slot 1, `dev_ack[1]` tied to `dev_sel[1]`, `dev_rdata` slot 1 = 32'hCAFE0001 → `cpu_ready` 2 cycles after accept, rdata = CAFE0001, err = 0.
- Write slot 2 offset 3 with be=4'b0011, data=32'h12345678, ack after 4 cycles → during strobe `dev_addr`=3, `dev_be`=3, `dev_wdata` matches; ready 5 cycles after accept.
- Read slot 0 with no ack, TIMEOUT=15 → `dev_sel` high exactly 15 cycles, then ready with err=1. Reading ERR_ADDR then returns the accessed byte address.
- Access `cpu_addr[31:4]`=28'h0000800 → ready after 1 cycle, err=1, no `dev_sel` activity.
- Write mask=4'b0100, raise `dev_irq[2]` then `dev_irq[1]` → `cpu_irq` rises 1 cycle after irq[2] and ignores irq[1]; pending reads 4'b0110.
- Assert `rst_n`=0 while in ACCESS → `dev_sel`, `cpu_ready`, mask and FSM clear immediately; the next request after release completes normally.
